// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   System-side SPI master (mode 0) for the SPI slave register-file block.
//   One request produces a 2-byte frame {rw, addr, data}, shifted MSB-first.
//   MISO is captured on SCK rising edges; the last DATA_WIDTH bits captured
//   form the read byte. Every output is registered.
//
// Ports
//   i_sys_clk   system clock, rising edge
//   i_rst       synchronous reset, active high
//   i_start     request strobe, taken only while idle (o_busy = 0)
//   i_rw        1 = write, 0 = read
//   i_addr      register address (DATA_WIDTH-1 bits)
//   i_wr_data   write data, ignored for reads
//   o_busy      high from the cycle after accept until the idle gap ends
//   o_rd_data   last read byte, held until the next read completes
//   o_rd_valid  1-cycle pulse when a read frame completes
//   o_done      1-cycle pulse when any frame completes
//   o_spi_sck   SPI clock, idles low
//   o_spi_mosi  SPI data out
//   o_spi_cs    chip select, active low
//   i_spi_miso  SPI data in
module spi_master_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 2,
  parameter int unsigned CS_IDLE    = 2
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_rw,
  input  logic [DATA_WIDTH-2:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_busy,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_done,
  output logic                  o_spi_sck,
  output logic                  o_spi_mosi,
  output logic                  o_spi_cs,
  input  logic                  i_spi_miso
);

  localparam int unsigned FRAME_W = 2 * DATA_WIDTH;
  localparam int unsigned CNT_MAX = (CS_SETUP > CS_HOLD)
                                  ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                                  : ((CS_HOLD  > CS_IDLE) ? CS_HOLD  : CS_IDLE);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_HOLD,
    S_GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [FRAME_W-1:0]      tx_q, tx_d;
  logic [DATA_WIDTH-1:0]   rx_q, rx_d;
  logic                    rw_q, rw_d;
  logic                    sck_q, sck_d;
  logic                    mosi_q, mosi_d;
  logic                    cs_q, cs_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0]   wr_byte;

  assign wr_byte = i_rw ? i_wr_data : '0;

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rw_q       <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rw_q       <= rw_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      cs_q       <= cs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Next-state logic also produces the next value of every output, so the
  // pins come straight from flops and line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rw_d       = rw_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    cs_d       = cs_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (i_start) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          rw_d    = i_rw;
          tx_d    = {i_rw, i_addr, wr_byte};
          mosi_d  = i_rw;  // frame MSB is the rw flag
        end
      end

      S_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          state_d = S_XFER;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_XFER: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            rx_d = {rx_q[DATA_WIDTH-2:0], i_spi_miso};
          end else begin
            tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
            mosi_d = tx_q[FRAME_W-2];
            bit_d  = bit_q + 1'b1;
            if (bit_q == BIT_W'(FRAME_W - 1)) begin
              state_d = S_HOLD;
              cnt_d   = '0;
              mosi_d  = 1'b0;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          state_d = S_GAP;
          cnt_d   = '0;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          if (!rw_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rx_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q == CNT_W'(CS_IDLE - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign o_busy     = busy_q;
  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_done     = done_q;
  assign o_spi_sck  = sck_q;
  assign o_spi_mosi = mosi_q;
  assign o_spi_cs   = cs_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl
//   Two instances: default timing, and the fastest legal timing
//   (CLK_DIV = CS_SETUP = CS_HOLD = CS_IDLE = 1). A frame-level model issues
//   expectations into a scoreboard at accept time; a monitor reconstructs each
//   frame from the pins, plays the slave, and checks against the scoreboard.
module tb_spi_master_ctrl;

  localparam int DW  = 8;
  localparam int DV0 = 4, SU0 = 2, HO0 = 2, ID0 = 2;
  localparam int DV1 = 1, SU1 = 1, HO1 = 1, ID1 = 1;
  localparam int T0  = 1 + SU0 + 4 * DW * DV0 + HO0;  // 133
  localparam int T1  = 1 + SU1 + 4 * DW * DV1 + HO1;  // 35

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst[2], start[2], rw[2];
  logic [DW-2:0] addr[2];
  logic [DW-1:0] wd[2];
  logic          busy[2], done[2], rdv[2], sck[2], mosi[2], cs[2];
  logic          miso[2];
  logic [DW-1:0] rdd[2];

  spi_master_ctrl #(.DATA_WIDTH(DW), .CLK_DIV(DV0), .CS_SETUP(SU0), .CS_HOLD(HO0), .CS_IDLE(ID0)) dut0 (
    .i_sys_clk(clk), .i_rst(rst[0]), .i_start(start[0]), .i_rw(rw[0]), .i_addr(addr[0]),
    .i_wr_data(wd[0]), .o_busy(busy[0]), .o_rd_data(rdd[0]), .o_rd_valid(rdv[0]), .o_done(done[0]),
    .o_spi_sck(sck[0]), .o_spi_mosi(mosi[0]), .o_spi_cs(cs[0]), .i_spi_miso(miso[0]));

  spi_master_ctrl #(.DATA_WIDTH(DW), .CLK_DIV(DV1), .CS_SETUP(SU1), .CS_HOLD(HO1), .CS_IDLE(ID1)) dut1 (
    .i_sys_clk(clk), .i_rst(rst[1]), .i_start(start[1]), .i_rw(rw[1]), .i_addr(addr[1]),
    .i_wr_data(wd[1]), .o_busy(busy[1]), .o_rd_data(rdd[1]), .o_rd_valid(rdv[1]), .o_done(done[1]),
    .o_spi_sck(sck[1]), .o_spi_mosi(mosi[1]), .o_spi_cs(cs[1]), .i_spi_miso(miso[1]));

  function automatic int t_of(int i);
    return (i == 0) ? T0 : T1;
  endfunction

  function automatic int idle_of(int i);
    return (i == 0) ? ID0 : ID1;
  endfunction

  typedef struct {
    int            inst;
    longint        acc;
    logic          rw;
    logic [2*DW-1:0] frame;
    logic [DW-1:0] resp;
  } exp_t;

  exp_t          sbq[$];
  longint        cyc = 0;
  bit            has_frame[2];
  longint        acc_e[2];
  logic [DW-1:0] cur_resp[2];
  logic [DW-1:0] next_resp[2];
  int            rst_cnt[2];
  int            total = 0;
  int            bad = 0;
  int            stim_to = 0;
  bit            fin_req = 1'b0;
  bit            fin_done = 1'b0;

  // Frame-level model: a request is taken when the master is free; it is free
  // again T + CS_IDLE cycles after the previous accept.
  always @(posedge clk) begin
    exp_t x;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        has_frame[i] = 1'b0;
        rst_cnt[i]++;
      end else if (start[i] && (!has_frame[i] ||
                 cyc >= acc_e[i] + longint'(t_of(i) + idle_of(i)))) begin
        has_frame[i] = 1'b1;
        acc_e[i]     = cyc;
        cur_resp[i]  = next_resp[i];
        x.inst  = i;
        x.acc   = cyc;
        x.rw    = rw[i];
        x.frame = {rw[i], addr[i], (rw[i] ? wd[i] : 8'h00)};
        x.resp  = next_resp[i];
        sbq.push_back(x);
      end
    end
  end

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst=%0d got=%0h want=%0h cyc=%0d", name, i, got, want, cyc);
    end
  endtask

  function automatic int find_inst(int i);
    foreach (sbq[k]) if (sbq[k].inst == i) return k;
    return -1;
  endfunction

  logic [2*DW-1:0] cap[2];
  int              rises[2], falls[2], rst_seen[2];
  logic            prev_sck[2], prev_cs[2];
  logic [DW-1:0]   last_rd[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      prev_cs[i] = 1'b1; prev_sck[i] = 1'b0; miso[i] = 1'b0;
      rises[i] = 0; falls[i] = 0; cap[i] = '0; rst_seen[i] = 0; last_rd[i] = '0;
    end
  end

  // Monitor / slave model, sampled mid-cycle.
  always @(negedge clk) begin
    longint e;
    bit     bz, cl;
    int     k, idx;
    exp_t   x;
    e = cyc;
    for (int i = 0; i < 2; i++) begin
      if (rst_cnt[i] != rst_seen[i]) begin
        rst_seen[i] = rst_cnt[i];
        last_rd[i]  = '0;
        for (int j = sbq.size() - 1; j >= 0; j--) if (sbq[j].inst == i) sbq.delete(j);
      end
      bz = has_frame[i] && (e <= acc_e[i] + longint'(t_of(i) + idle_of(i) - 2));
      cl = has_frame[i] && (e <= acc_e[i] + longint'(t_of(i) - 2));
      chk("busy", i, 32'(busy[i]), 32'(bz));
      chk("cs", i, 32'(cs[i]), 32'(!cl));
      if (!cl) begin
        chk("sck_idle", i, 32'(sck[i]), 32'(0));
        chk("mosi_idle", i, 32'(mosi[i]), 32'(0));
      end
      if (cs[i] == 1'b0) begin
        if (prev_cs[i]) begin cap[i] = '0; rises[i] = 0; falls[i] = 0; end
        if (sck[i] && !prev_sck[i]) begin cap[i] = {cap[i][2*DW-2:0], mosi[i]}; rises[i]++; end
        if (!sck[i] && prev_sck[i]) falls[i]++;
      end
      if (done[i]) begin
        k = find_inst(i);
        if (k < 0) chk("done_spurious", i, 32'(1), 32'(0));
        else begin
          x = sbq[k];
          sbq.delete(k);
          chk("done_latency", i, 32'(e - x.acc), 32'(t_of(i) - 1));
          chk("mosi_frame", i, 32'(cap[i]), 32'(x.frame));
          chk("sck_rises", i, 32'(rises[i]), 32'(2 * DW));
          chk("rd_valid", i, 32'(rdv[i]), 32'(!x.rw));
          if (!x.rw) last_rd[i] = x.resp;
        end
      end
      chk("rdv_without_done", i, 32'(rdv[i] & ~done[i]), 32'(0));
      chk("rd_data", i, 32'(rdd[i]), 32'(last_rd[i]));
      k = find_inst(i);
      if (k >= 0 && e > sbq[k].acc + longint'(t_of(i) + 4)) begin
        chk("done_timeout", i, 32'(0), 32'(1));
        sbq.delete(k);
      end
      prev_cs[i]  = cs[i];
      prev_sck[i] = sck[i];
      // Mode-0 slave: data byte bits MSB-first, changing after each SCK fall.
      idx = falls[i];
      if (cs[i] == 1'b0 && idx >= DW && idx < 2 * DW) miso[i] = cur_resp[i][2*DW-1-idx];
      else miso[i] = 1'($urandom);
    end
    if (fin_req && !fin_done) begin
      chk("scoreboard_empty", 0, 32'(sbq.size()), 32'(0));
      chk("stim_wait_timeouts", 0, 32'(stim_to), 32'(0));
      fin_done = 1'b1;
    end
  end

  task automatic wait_idle(input int i);
    int n = 0;
    while (has_frame[i] && (cyc + 1 < acc_e[i] + longint'(t_of(i) + idle_of(i)))) begin
      @(negedge clk);
      n++;
      if (n > 1000) begin
        stim_to++;
        break;
      end
    end
  endtask

  task automatic send(input int i, input logic r_w, input logic [DW-2:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] resp);
    wait_idle(i);
    rw[i] = r_w; addr[i] = a; wd[i] = d; next_resp[i] = resp; start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic held_start(input int i, input int ncyc);
    rw[i] = 1'b0; addr[i] = 7'($urandom); wd[i] = 8'($urandom); start[i] = 1'b1;
    repeat (ncyc) begin
      next_resp[i] = 8'($urandom);
      @(negedge clk);
    end
    start[i] = 1'b0;
  endtask

  task automatic rand_frames(input int i, input int n);
    repeat (n) begin
      send(i, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        start[i] = 1'b1; rw[i] = 1'($urandom); addr[i] = 7'($urandom);
        @(negedge clk);
        start[i] = 1'b0;
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; rw[i] = 1'b0; addr[i] = '0; wd[i] = '0; next_resp[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;

    send(0, 1'b1, 7'h05, 8'hA5, 8'h00);
    send(0, 1'b0, 7'h12, 8'h00, 8'h3C);

    // Requests arriving mid-frame must be dropped.
    send(0, 1'b0, 7'h33, 8'h00, 8'h96);
    repeat (9) @(negedge clk);
    start[0] = 1'b1; rw[0] = 1'b1; addr[0] = 7'h7F;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (39) @(negedge clk);
    start[0] = 1'b1; rw[0] = 1'b0; addr[0] = 7'h01;
    @(negedge clk);
    start[0] = 1'b0;

    // Reset in the middle of a frame, then a clean frame.
    send(0, 1'b1, 7'h2A, 8'h5A, 8'h00);
    repeat (39) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    send(0, 1'b0, 7'h44, 8'h00, 8'hC3);

    held_start(0, 3 * (T0 + ID0) + 5);
    rand_frames(0, 8);

    held_start(1, 4 * (T1 + ID1) + 3);
    rand_frames(1, 25);
    send(1, 1'b0, 7'h10, 8'h00, 8'h81);
    repeat (12) @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    rand_frames(1, 5);

    repeat (T0 + 10) @(negedge clk);
    fin_req = 1'b1;
    repeat (4) @(negedge clk);
    if (!fin_done) begin
      bad++;
      $display("FAIL final_checks got=0 want=1");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
